// File: rtl/crc_pkg.sv
// Shared constants and types for the serial CRC encoder/decoder pair.
// CRC5 covers token packets, CRC16 covers data packets.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    PASS  = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam int CRC5_LEN  = 5;
  localparam int CRC16_LEN = 16;

  localparam logic [4:0]  CRC5_POLY      = 5'b00101;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // Bit counter saturates here; it only needs to reach the longest CRC width.
  localparam logic [4:0] CNT_SAT = 5'd16;

  function automatic logic [4:0] crc_len(input logic is_crc16);
    return is_crc16 ? 5'(CRC16_LEN) : 5'(CRC5_LEN);
  endfunction

endpackage

// File: rtl/crc_check_reg.sv
// Serial CRC LFSR, MSB-first feedback, preset to all ones.
// clr has priority over shift.
module crc_check_reg #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] crc
);

  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_d;
  logic             fb;

  always_comb begin
    fb    = din ^ crc_q[WIDTH-1];
    crc_d = crc_q;
    if (clr) begin
      crc_d = '1;
    end else if (shift) begin
      crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      crc_q <= '1;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc_decode.sv
// Receive-side CRC checker: strips the trailing CRC from a serial packet body,
// forwards payload bits one cycle after acceptance, and reports pass/fail on done.
module crc_decode
  import crc_pkg::*;
(
  input  logic   clk,
  input  logic   rst_L,
  input  logic   inb,
  input  logic   bit_valid,
  input  logic   recving,
  input  logic   pkttype,
  output logic   outb,
  output logic   out_valid,
  output logic   sending,
  output logic   done,
  output logic   crc_ok,
  output state_t dbg_state
);

  state_t      state_q, state_d;
  logic        type_q, type_d;
  logic [4:0]  count_q, count_d;
  logic [15:0] dly_q, dly_d;
  logic        outb_q, outb_d;
  logic        out_valid_q, out_valid_d;
  logic        sending_q, sending_d;
  logic        done_q, done_d;
  logic        crc_ok_q, crc_ok_d;

  logic        accept;
  logic        crc_clr;
  logic [4:0]  len;
  logic [4:0]  count_inc;
  logic        tap;
  logic        crc_match;
  logic [4:0]  crc5_val;
  logic [15:0] crc16_val;

  // Upstream has no backpressure: a bit is consumed on every cycle with
  // recving & bit_valid, except during CHECK where a new packet is not allowed.
  assign accept  = recving & bit_valid & (state_q != CHECK);
  assign crc_clr = (state_q == CHECK) | ((state_q == IDLE) & ~accept);

  crc_check_reg #(
    .WIDTH (CRC5_LEN),
    .POLY  (CRC5_POLY)
  ) u_crc5 (
    .clk   (clk),
    .rst_L (rst_L),
    .clr   (crc_clr),
    .shift (accept),
    .din   (inb),
    .crc   (crc5_val)
  );

  crc_check_reg #(
    .WIDTH (CRC16_LEN),
    .POLY  (CRC16_POLY)
  ) u_crc16 (
    .clk   (clk),
    .rst_L (rst_L),
    .clr   (crc_clr),
    .shift (accept),
    .din   (inb),
    .crc   (crc16_val)
  );

  assign len       = crc_len(type_q);
  assign count_inc = (count_q == CNT_SAT) ? CNT_SAT : count_q + 5'd1;
  // The bit accepted N bits ago is the oldest one still in the CRC window.
  assign tap       = type_q ? dly_q[CRC16_LEN-1] : dly_q[CRC5_LEN-1];
  assign crc_match = type_q ? (crc16_val == CRC16_RESIDUAL)
                            : (crc5_val == CRC5_RESIDUAL);

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    count_d     = count_q;
    dly_d       = dly_q;
    outb_d      = 1'b0;
    out_valid_d = 1'b0;
    sending_d   = sending_q;
    done_d      = 1'b0;
    crc_ok_d    = crc_ok_q;

    if (accept) begin
      dly_d = {dly_q[14:0], inb};
    end

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (accept) begin
          type_d    = pkttype;
          count_d   = 5'd1;
          sending_d = 1'b1;
          crc_ok_d  = 1'b0;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (!recving) begin
          done_d   = 1'b1;
          crc_ok_d = (count_q >= len) & crc_match;
          state_d  = CHECK;
        end else if (accept) begin
          count_d = count_inc;
          if (count_inc >= len) begin
            state_d = PASS;
          end
        end
      end
      PASS: begin
        if (!recving) begin
          done_d   = 1'b1;
          crc_ok_d = (count_q >= len) & crc_match;
          state_d  = CHECK;
        end else if (accept) begin
          count_d     = count_inc;
          outb_d      = tap;
          out_valid_d = 1'b1;
        end
      end
      CHECK: begin
        // The buffered CRC tail is dropped here, never emitted.
        count_d   = '0;
        dly_d     = '0;
        sending_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= IDLE;
      type_q      <= 1'b0;
      count_q     <= '0;
      dly_q       <= '0;
      outb_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sending_q   <= 1'b0;
      done_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      count_q     <= count_d;
      dly_q       <= dly_d;
      outb_q      <= outb_d;
      out_valid_q <= out_valid_d;
      sending_q   <= sending_d;
      done_q      <= done_d;
      crc_ok_q    <= crc_ok_d;
    end
  end

  assign outb      = outb_q;
  assign out_valid = out_valid_q;
  assign sending   = sending_q;
  assign done      = done_q;
  assign crc_ok    = crc_ok_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_crc_decode.sv
// Directed bench for crc_decode: token and data packets, short and zero-length
// packets, gap cycles and a mid-packet reset.
module tb_crc_decode;
  import crc_pkg::*;

  logic   clk       = 1'b0;
  logic   rst_L     = 1'b0;
  logic   inb       = 1'b0;
  logic   bit_valid = 1'b0;
  logic   recving   = 1'b0;
  logic   pkttype   = 1'b0;
  logic   outb;
  logic   out_valid;
  logic   sending;
  logic   done;
  logic   crc_ok;
  state_t dbg_state;

  int n_vec    = 0;
  int n_err    = 0;
  int out_cnt  = 0;
  int done_cnt = 0;

  logic [0:0] exp_q[$];
  logic [0:0] pkt_q[$];

  crc_decode dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .inb       (inb),
    .bit_valid (bit_valid),
    .recving   (recving),
    .pkttype   (pkttype),
    .outb      (outb),
    .out_valid (out_valid),
    .sending   (sending),
    .done      (done),
    .crc_ok    (crc_ok),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard on the output stream ----------------
  always @(negedge clk) begin
    if (rst_L && out_valid) begin
      out_cnt++;
      chk("out_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [0:0] e;
        e = exp_q.pop_front();
        chk("outb", 32'(outb), 32'(e));
      end
    end
    if (rst_L && done) done_cnt++;
  end

  // ---------------- reference CRC16 for stimulus ----------------
  function automatic logic [15:0] crc16_ref(input logic [63:0] p);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 63; i >= 0; i--) begin
      fb = p[i] ^ r[15];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h8005;
    end
    return ~r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) pkt_q.push_back(v[i]);
  endtask

  task automatic drive_bit(input logic b);
    inb       = b;
    bit_valid = 1'b1;
    recving   = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive_gap();
    inb       = 1'($urandom_range(0, 1));
    bit_valid = 1'b0;
    recving   = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic finish_pkt(input string tag, input logic exp_ok, input int exp_outs);
    logic got;
    logic ok;
    got       = 1'b0;
    ok        = 1'b0;
    recving   = 1'b0;
    bit_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        ok  = crc_ok;
        break;
      end
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_crc_ok"}, 32'(ok), 32'(exp_ok));
    chk({tag, "_out_cnt"}, 32'(out_cnt), 32'(exp_outs));
    chk({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_sending_off"}, 32'(sending), 32'd0);
    chk({tag, "_crc_ok_held"}, 32'(crc_ok), 32'(exp_ok));
    exp_q.delete();
  endtask

  // Sends pkt_q; the leading (size - N) bits are the payload expected downstream.
  task automatic send_pkt(input string tag, input logic ptype, input int gap_pct,
                          input logic exp_ok);
    int n;
    int outs;
    n       = ptype ? 16 : 5;
    outs    = (pkt_q.size() > n) ? pkt_q.size() - n : 0;
    out_cnt = 0;
    exp_q.delete();
    for (int i = 0; i < outs; i++) exp_q.push_back(pkt_q[i]);
    pkttype = ptype;
    for (int i = 0; i < pkt_q.size(); i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) drive_gap();
      drive_bit(pkt_q[i]);
      if (i == 0) begin
        chk({tag, "_sending_on"}, 32'(sending), 32'd1);
        pkttype = ~ptype;
      end
    end
    finish_pkt(tag, exp_ok, outs);
    pkt_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] payload;
    logic [15:0] crc16;
    int          dc;

    // reset state
    rst_L = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outb", 32'(outb), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sending", 32'(sending), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_crc_ok", 32'(crc_ok), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_L = 1'b1;
    @(posedge clk); #1;

    // recving high with no valid bits must not start a packet
    recving   = 1'b1;
    bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_wait_state", 32'(dbg_state), 32'(IDLE));
    chk("idle_wait_sending", 32'(sending), 32'd0);
    recving = 1'b0;
    @(posedge clk); #1;

    // token: 11 zero bits + CRC 01000
    push_bits(64'h0, 11);
    push_bits(64'h08, 5);
    send_pkt("tok_good", 1'b0, 0, 1'b1);

    // token with CRC bit 2 flipped
    push_bits(64'h0, 11);
    push_bits(64'h0C, 5);
    send_pkt("tok_bad", 1'b0, 0, 1'b0);

    // short data packet: 7 bits, never reaches the CRC width
    push_bits(64'h59, 7);
    send_pkt("short", 1'b1, 0, 1'b0);

    // 64-bit data payload with gaps, correct CRC16
    payload = {$urandom, $urandom};
    crc16   = crc16_ref(payload);
    push_bits(payload, 64);
    push_bits(64'(crc16), 16);
    send_pkt("data_good", 1'b1, 30, 1'b1);

    // same CRC, one payload bit flipped
    push_bits(payload ^ (64'd1 << 17), 64);
    push_bits(64'(crc16), 16);
    send_pkt("data_flip", 1'b1, 30, 1'b0);

    // zero-length data packet: CRC of nothing is 16 zero bits
    push_bits(64'h0, 16);
    send_pkt("data_empty", 1'b1, 0, 1'b1);

    // mid-packet reset while in PASS: 8 token bits, first 3 are forwarded
    out_cnt = 0;
    exp_q.delete();
    push_bits(64'h17, 8);
    for (int i = 0; i < 3; i++) exp_q.push_back(pkt_q[i]);
    pkttype = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit(pkt_q[i]);
    pkt_q.delete();
    chk("mid_state", 32'(dbg_state), 32'(PASS));
    @(negedge clk);
    #2;
    dc        = done_cnt;
    rst_L     = 1'b0;
    recving   = 1'b0;
    bit_valid = 1'b0;
    #1;
    chk("arst_outb", 32'(outb), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_sending", 32'(sending), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_crc_ok", 32'(crc_ok), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    chk("arst_out_cnt", 32'(out_cnt), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    rst_L = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_done", 32'(done_cnt), 32'(dc));
    exp_q.delete();

    // clean token after reset
    push_bits(64'h0, 11);
    push_bits(64'h08, 5);
    send_pkt("tok_after_rst", 1'b0, 20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
